// File: rtl/mux_scan_seq.sv
// Registered N-channel multiplexer with a manual select mode and an auto-scan mode
// that walks the enabled channels, handshakes each one, then dwells before the next.
module mux_scan_seq #(
    parameter int WIDTH = 18,
    parameter int N_CH  = 11,
    parameter int SEL_W = 4,
    parameter int DWELL = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Modo,
    input  logic [SEL_W-1:0]        Sel,
    input  logic [N_CH-1:0]         Mascara,
    input  logic                    Listo,
    input  logic [N_CH*WIDTH-1:0]   Dat,
    output logic [WIDTH-1:0]        DatSal,
    output logic [SEL_W-1:0]        SelSal,
    output logic                    Valido,
    output logic                    FueraRango
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    if (N_CH < 2 || (1 << SEL_W) < N_CH || DWELL < 1) begin : g_bad_params
        $error("mux_scan_seq: illegal N_CH/SEL_W/DWELL combination");
    end

    typedef enum logic [1:0] {
        MANUAL,
        SCAN_LOAD,
        SCAN_WAIT,
        SCAN_DWELL
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [CW-1:0]      cnt;

    logic [SEL_W-1:0]   next_ch;
    logic               any_en;
    logic               sel_ok;
    logic [WIDTH-1:0]   man_data;
    logic [WIDTH-1:0]   scan_data;

    // Rotating priority search starting just after ptr; mask bits are read by shift
    // so only channels below N_CH can ever match.
    always_comb begin
        int          idx;
        logic        found;
        logic [N_CH-1:0] cand;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        next_ch = ptr;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx  = (int'(ptr) + 1 + i) % N_CH;
            cand = Mascara >> idx;
            if (!found && cand[0]) begin
                found   = 1'b1;
                next_ch = SEL_W'(idx);
            end
        end
    end

    assign any_en = |Mascara;
    assign sel_ok = int'(Sel) < N_CH;

    always_comb begin
        man_data  = '0;
        scan_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(Sel) == k)     man_data  = Dat[k*WIDTH +: WIDTH];
            if (int'(next_ch) == k) scan_data = Dat[k*WIDTH +: WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= MANUAL;
            ptr        <= SEL_W'(N_CH - 1);
            cnt        <= '0;
            DatSal     <= '0;
            SelSal     <= '0;
            Valido     <= 1'b0;
            FueraRango <= 1'b0;
        end else begin
            case (state)
                MANUAL: begin
                    SelSal     <= Sel;
                    FueraRango <= !sel_ok;
                    if (sel_ok) begin
                        DatSal <= man_data;
                        Valido <= 1'b1;
                        ptr    <= Sel;
                    end else begin
                        DatSal <= '0;
                        Valido <= 1'b0;
                    end
                    if (Modo) state <= SCAN_LOAD;
                end
                SCAN_LOAD: begin
                    FueraRango <= 1'b0;
                    if (!Modo) begin
                        state <= MANUAL;
                    end else if (any_en) begin
                        DatSal <= scan_data;
                        SelSal <= next_ch;
                        ptr    <= next_ch;
                        Valido <= 1'b1;
                        state  <= SCAN_WAIT;
                    end else begin
                        DatSal <= '0;
                        Valido <= 1'b0;
                    end
                end
                SCAN_WAIT: begin
                    if (!Modo) begin
                        state <= MANUAL;
                    end else if (Listo) begin
                        Valido <= 1'b0;
                        cnt    <= '0;
                        state  <= SCAN_DWELL;
                    end
                end
                SCAN_DWELL: begin
                    Valido <= 1'b0;
                    if (!Modo) begin
                        state <= MANUAL;
                    end else if (cnt == CW'(DWELL - 1)) begin
                        state <= SCAN_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= MANUAL;
            endcase
        end
    end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Parametrised, registered N-channel multiplexer with a built-in channel scanner, for routing per-channel W-bit results to one shared consumer. In manual mode it is a registered mux driven by `Sel`, and out-of-range selects force zero. In auto mode it cycles through enabled channels, presents each one with a valid/ready handshake, and holds each channel for a programmable dwell time. It sits between the parallel datapath results and the single display/serial output stage.

Parameters:
- WIDTH, 18, data width per channel.
- N_CH, 11, number of channels; legal range 2..2^SEL_W.
- SEL_W, 4, select/channel-index width.
- DWELL, 3, cycles spent in SCAN_DWELL after each handshake; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Modo  in  1  0 = manual select, 1 = auto scan.
- Sel  in  SEL_W  manual channel select.
- Mascara  in  N_CH  channel-enable mask for auto scan; bit k enables channel k.
- Listo  in  1  consumer ready.
- Dat  in  N_CH*WIDTH  packed inputs; channel k is at bits [k*WIDTH +: WIDTH].
- DatSal  out  WIDTH  registered selected data.
- SelSal  out  SEL_W  index of the channel currently on DatSal.
- Valido  out  1  DatSal is valid.
- FueraRango  out  1  manual Sel is at or above N_CH.

Behaviour:
- Reset is asynchronous, active-high, and applies immediately, including mid-operation:
  - DatSal = 0, SelSal = 0, Valido = 0, FueraRango = 0.
  - State = MANUAL, dwell counter = 0.
  - Scan pointer `ptr` = N_CH-1, so the first scan selects the lowest enabled channel.
- All outputs are registered. Data latency is 1 cycle from the Dat/Sel sample to DatSal.
- States: MANUAL, SCAN_LOAD, SCAN_WAIT, SCAN_DWELL.
- Mode switching, evaluated every cycle:
  - Modo=0 in any SCAN state -> MANUAL on the next edge.
  - Modo=1 in MANUAL -> SCAN_LOAD on the next edge.
  - Scan-state transitions below apply only while Modo=1.
- MANUAL:
  - Each edge: SelSal <= Sel and FueraRango <= (Sel >= N_CH).
  - If Sel < N_CH: DatSal <= channel Sel, Valido <= 1, ptr <= Sel.
  - If Sel >= N_CH: DatSal <= 0, Valido <= 0, ptr unchanged.
  - Listo is ignored.
- Next-channel search (combinational): lowest-distance enabled channel c = (ptr+1+i) mod N_CH, for i = 0..N_CH-1.
  - Wraps past N_CH-1 to 0.
  - Mascara bits at or above N_CH do not exist; there is no aliasing.
  - If ptr is the only enabled channel, it is selected again.
- SCAN_LOAD:
  - If the mask is nonzero: DatSal <= channel c, SelSal <= c, ptr <= c, Valido <= 1, FueraRango <= 0, go to SCAN_WAIT.
  - If Mascara == 0: DatSal <= 0, Valido <= 0, FueraRango <= 0, SelSal and ptr held, stay in SCAN_LOAD.
- SCAN_WAIT:
  - DatSal, SelSal and Valido are held stable. DatSal is not re-sampled, even if Dat changes.
  - On Listo=1: Valido <= 0, dwell counter <= 0, go to SCAN_DWELL.
  - While Listo=0: stay indefinitely (back-pressure).
- SCAN_DWELL:
  - Valido = 0; the counter increments each cycle.
  - When the counter reaches DWELL-1, go to SCAN_LOAD.
  - Mascara changes take effect at the next SCAN_LOAD.
- Steady-state period with Listo tied high: DWELL+2 cycles per channel, with Valido high for 1 cycle.
- Channel disabled while displayed in SCAN_WAIT: the handshake still completes normally, and the search skips that channel afterwards.
- Simultaneous Listo=1 and Modo→0 in SCAN_WAIT: mode switching wins, so the next state is MANUAL. The consumer treats this handshake as accepted.
- SEL_W/N_CH checks: elaboration fails if 2^SEL_W < N_CH or DWELL < 1.

Test Plan:
1. Reset with Modo=0, Sel=5, Dat5=18'h2A5A5 -> all outputs 0 during reset. First edge after release: DatSal=18'h2A5A5, SelSal=5, Valido=1, FueraRango=0.
2. Manual, Sel=4'd11 then 4'd15 -> DatSal=0, Valido=0, FueraRango=1. Then Sel=10 -> Dat10, FueraRango=0, 1-cycle latency.
3. Auto, Mascara=11'b100_0000_0101, Listo=1, DWELL=3 -> SelSal sequence 0,2,10,0,2…. Valido pulses every 5 cycles, and DatSal matches each channel.
4. Auto, Listo=0 for 7 cycles in SCAN_WAIT while Dat2 changes -> DatSal/Valido/SelSal held at the loaded value. Listo=1 -> Valido drops next edge, next load after DWELL cycles.
5. Auto, Mascara=0 -> Valido=0, DatSal=0 indefinitely. Set Mascara bit 7 -> SelSal=7 and Valido=1 within 2 cycles, then channel 7 repeats.
6. Assert reset mid-SCAN_DWELL on channel 2 -> outputs cleared asynchronously. After release with Modo=1, the first load selects the lowest enabled channel (ptr restored to N_CH-1).
